// File: rtl/cpfsk_demod.sv
`default_nettype none
// ============================================================================
// Module   : cpfsk_demod
// Purpose  : CPFSK demodulator for the beacon audio stream. Measures the
//            tone period between rising midscale crossings, classifies it as
//            mark (long period, data 1) or space (short period, data 0),
//            tracks carrier presence and slices one data bit per bit period
//            with resynchronisation on every tone change.
// Ports    : clk_in        system clock, all logic on posedge
//            sys_rst_n     asynchronous active-low reset
//            sample_valid  qualifies sample_in (at most one per cycle)
//            sample_in     8-bit offset-binary audio sample, midscale 8'h80
//            tone          latest period classification, 1 = mark
//            carrier_ok    valid tone present
//            data_out      recovered bit, held between strobes
//            data_valid    one-cycle strobe when data_out is updated
// Revision : 1.0 - initial release
// ============================================================================
module cpfsk_demod #(
  parameter int SAMPLES_PER_BIT = 66,
  parameter int PERIOD_THRESH   = 9,
  parameter int MIN_PERIOD      = 4,
  parameter int MAX_PERIOD      = 15
) (
  input  logic       clk_in,
  input  logic       sys_rst_n,
  input  logic       sample_valid,
  input  logic [7:0] sample_in,
  output logic       tone,
  output logic       carrier_ok,
  output logic       data_out,
  output logic       data_valid
);

  localparam int BCNT_W = $clog2(SAMPLES_PER_BIT);

  localparam logic [4:0]        C_PCNT_SAT  = 5'd31;
  localparam logic [4:0]        C_PCNT_ONE  = 5'd1;
  localparam logic [4:0]        C_MIN       = 5'(MIN_PERIOD);
  localparam logic [4:0]        C_MAX       = 5'(MAX_PERIOD);
  localparam logic [4:0]        C_THRESH    = 5'(PERIOD_THRESH);
  localparam logic [1:0]        C_GOOD_SAT  = 2'd2;
  localparam logic [1:0]        C_GOOD_ONE  = 2'd1;
  localparam logic [BCNT_W-1:0] C_BCNT_ZERO = '0;
  localparam logic [BCNT_W-1:0] C_BCNT_ONE  = BCNT_W'(1);
  localparam logic [BCNT_W-1:0] C_BCNT_LAST = BCNT_W'(SAMPLES_PER_BIT - 1);
  localparam logic [BCNT_W-1:0] C_BCNT_MID  = BCNT_W'(SAMPLES_PER_BIT / 2 - 1);

  logic              prev_msb_q, prev_msb_d;
  logic [4:0]        pcnt_q,     pcnt_d;
  logic [1:0]        good_cnt_q, good_cnt_d;
  logic              tone_q,     tone_d;
  logic              carrier_q,  carrier_d;
  logic [BCNT_W-1:0] bcnt_q,     bcnt_d;
  logic              data_q,     data_d;
  logic              dv_q,       dv_d;

  logic w_cross;
  logic w_in_range;
  logic w_new_tone;
  logic w_resync;
  logic w_unused_lsbs;

  // Only the sign bit matters for midscale crossing detection.
  assign w_unused_lsbs = ^sample_in[6:0];

  assign w_cross    = ~prev_msb_q & sample_in[7];
  // pcnt_q holds the period being measured when a crossing arrives.
  assign w_in_range = (pcnt_q >= C_MIN) && (pcnt_q <= C_MAX);
  assign w_new_tone = (pcnt_q >= C_THRESH);
  // A valid period of the other tone marks a bit boundary.
  assign w_resync   = w_cross & w_in_range & (w_new_tone != tone_q);

  always_comb begin
    prev_msb_d = prev_msb_q;
    pcnt_d     = pcnt_q;
    good_cnt_d = good_cnt_q;
    tone_d     = tone_q;
    carrier_d  = carrier_q;
    bcnt_d     = bcnt_q;
    data_d     = data_q;
    dv_d       = 1'b0;

    if (sample_valid) begin
      prev_msb_d = sample_in[7];

      // Period measurement, classification and carrier tracking
      if (w_cross) begin
        pcnt_d = C_PCNT_ONE;
        if (w_in_range) begin
          tone_d = w_new_tone;
          if (good_cnt_q != C_GOOD_SAT) begin
            good_cnt_d = good_cnt_q + C_GOOD_ONE;
          end
          // This is the second (or later) consecutive good period.
          if (good_cnt_q != 2'd0) begin
            carrier_d = 1'b1;
          end
        end else begin
          good_cnt_d = 2'd0;
          carrier_d  = 1'b0;
        end
      end else begin
        if (pcnt_q != C_PCNT_SAT) begin
          pcnt_d = pcnt_q + C_PCNT_ONE;
        end
        // Counting past the longest legal period means crossings stopped.
        if (pcnt_q >= C_MAX) begin
          good_cnt_d = 2'd0;
          carrier_d  = 1'b0;
        end
      end

      // Bit slicer. A carrier rising edge always starts from carrier_q = 0,
      // so the first branch also covers the rising-edge restart.
      if (!carrier_q) begin
        bcnt_d = C_BCNT_ZERO;
      end else if (w_resync) begin
        bcnt_d = C_BCNT_ZERO;
      end else begin
        if (bcnt_q == C_BCNT_MID) begin
          data_d = tone_q;
          dv_d   = 1'b1;
        end
        if (bcnt_q == C_BCNT_LAST) begin
          bcnt_d = C_BCNT_ZERO;
        end else begin
          bcnt_d = bcnt_q + C_BCNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prev_msb_q <= 1'b1;
      pcnt_q     <= C_PCNT_SAT;
      good_cnt_q <= 2'd0;
      tone_q     <= 1'b0;
      carrier_q  <= 1'b0;
      bcnt_q     <= C_BCNT_ZERO;
      data_q     <= 1'b0;
      dv_q       <= 1'b0;
    end else begin
      prev_msb_q <= prev_msb_d;
      pcnt_q     <= pcnt_d;
      good_cnt_q <= good_cnt_d;
      tone_q     <= tone_d;
      carrier_q  <= carrier_d;
      bcnt_q     <= bcnt_d;
      data_q     <= data_d;
      dv_q       <= dv_d;
    end
  end

  assign tone       = tone_q;
  assign carrier_ok = carrier_q;
  assign data_out   = data_q;
  assign data_valid = dv_q;

endmodule
`default_nettype wire
